// File: rtl/float_ratio_div.sv
// Iterative float32 divider forming Q/I for the arctan LUT stage.
// Radix-2 restoring mantissa division; specials and out-of-range quotients saturate.
module float_ratio_div #(
    parameter logic [30:0] SAT_VALUE = 31'h7F7FFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] num_q,
    input  logic [31:0] num_i,
    output logic        out_valid,
    output logic [31:0] num_ratio,
    output logic        out_special
);

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StDivide,
        StNorm,
        StDone
    } state_e;

    state_e      state_q;
    logic [31:0] opq_q;
    logic [31:0] opi_q;
    logic [24:0] rem_q;
    logic [24:0] qt_q;
    logic [4:0]  cnt_q;

    logic        sign;
    logic [7:0]  eq;
    logic [7:0]  ei;
    logic [23:0] mq;
    logic [23:0] mi;
    logic        sat_in;
    logic        zero_in;

    logic        qbit;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;

    logic signed [9:0] exp_norm;
    logic [22:0]       mant_norm;
    logic [31:0]       norm_ratio;
    logic              norm_special;

    assign in_ready = (state_q == StIdle) & ~rst;

    // Operand fields, decoded from the registered pair.
    always_comb begin
        sign    = opq_q[31] ^ opi_q[31];
        eq      = opq_q[30:23];
        ei      = opi_q[30:23];
        mq      = {1'b1, opq_q[22:0]};
        mi      = {1'b1, opi_q[22:0]};
        sat_in  = (eq == 8'hFF) | (ei == 8'hFF) | (ei == 8'h00);
        zero_in = (eq == 8'h00);
    end

    // One restoring step; the remainder always stays below 2*mi so 25 bits suffice.
    always_comb begin
        qbit     = (rem_q >= {1'b0, mi});
        rem_sub  = qbit ? (rem_q - {1'b0, mi}) : rem_q;
        rem_next = rem_sub << 1;
    end

    always_comb begin
        exp_norm  = $signed({2'b00, eq}) - $signed({2'b00, ei})
                  + (qt_q[24] ? 10'sd127 : 10'sd126);
        mant_norm = qt_q[24] ? qt_q[23:1] : qt_q[22:0];
        if (exp_norm > 10'sd254) begin
            norm_ratio   = {sign, SAT_VALUE};
            norm_special = 1'b1;
        end else if (exp_norm < 10'sd1) begin
            norm_ratio   = 32'h0000_0000;
            norm_special = 1'b0;
        end else begin
            norm_ratio   = {sign, exp_norm[7:0], mant_norm};
            norm_special = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            opq_q       <= 32'h0;
            opi_q       <= 32'h0;
            rem_q       <= 25'h0;
            qt_q        <= 25'h0;
            cnt_q       <= 5'd0;
            num_ratio   <= 32'h0;
            out_special <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        opq_q   <= num_q;
                        opi_q   <= num_i;
                        state_q <= StUnpack;
                    end
                end
                StUnpack: begin
                    if (sat_in) begin
                        num_ratio   <= {sign, SAT_VALUE};
                        out_special <= 1'b1;
                        out_valid   <= 1'b1;
                        state_q     <= StDone;
                    end else if (zero_in) begin
                        num_ratio   <= 32'h0;
                        out_special <= 1'b0;
                        out_valid   <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        rem_q   <= {1'b0, mq};
                        qt_q    <= 25'h0;
                        cnt_q   <= 5'd24;
                        state_q <= StDivide;
                    end
                end
                StDivide: begin
                    rem_q <= rem_next;
                    qt_q  <= {qt_q[23:0], qbit};
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    num_ratio   <= norm_ratio;
                    out_special <= norm_special;
                    out_valid   <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_ratio_div.sv
// Self-checking bench for float_ratio_div: vector table plus scoreboard queue,
// back-to-back throughput and reset-mid-divide sequences.
module tb_float_ratio_div;

    typedef struct {
        logic [31:0] q;
        logic [31:0] i;
        logic [31:0] ratio;
        logic        special;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] ratio;
        logic        special;
        int          lat;
        int          acc;
    } exp_t;

    localparam int LatNorm = 27;  // edges from acceptance to the edge entering DONE
    localparam int LatSpec = 1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] num_q;
    logic [31:0] num_i;
    logic        out_valid;
    logic [31:0] num_ratio;
    logic        out_special;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_count = 0;
    int last_acc_cyc = 0;

    logic [31:0] cur_ratio;
    logic        cur_special;
    int          cur_lat;
    logic [31:0] last_ratio;

    exp_t sb[$];
    vec_t vecs[11];

    float_ratio_div dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .num_q      (num_q),
        .num_i      (num_i),
        .out_valid  (out_valid),
        .num_ratio  (num_ratio),
        .out_special(out_special)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, pops expectations on out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_ratio = num_ratio;
        end else begin
            if (sb.size() > 0) begin
                checks++;
                if (in_ready) begin
                    failures++;
                    $display("FAIL in_ready_busy: got 1 want 0 at cycle %0d", cyc);
                end
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid: num_ratio=%08h at cycle %0d",
                             num_ratio, cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (num_ratio !== e.ratio) begin
                        failures++;
                        $display("FAIL ratio: got %08h want %08h", num_ratio, e.ratio);
                    end
                    checks++;
                    if (out_special !== e.special) begin
                        failures++;
                        $display("FAIL special: got %0b want %0b (ratio %08h)",
                                 out_special, e.special, e.ratio);
                    end
                    checks++;
                    if (cyc - e.acc != e.lat) begin
                        failures++;
                        $display("FAIL latency: got %0d want %0d edges (ratio %08h)",
                                 cyc - e.acc, e.lat, e.ratio);
                    end
                end
                last_ratio = num_ratio;
            end else begin
                checks++;
                if (num_ratio !== last_ratio) begin
                    failures++;
                    $display("FAIL ratio_hold: got %08h want %08h", num_ratio, last_ratio);
                end
            end
            if (in_valid && in_ready) begin
                e.ratio   = cur_ratio;
                e.special = cur_special;
                e.lat     = cur_lat;
                e.acc     = cyc + 1;
                sb.push_back(e);
                acc_count++;
                last_acc_cyc = cyc + 1;
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %08h want %08h", name, got, want);
        end
    endtask

    task automatic send(input vec_t v, input bit hold);
        int  start;
        bit  ok;
        num_q       = v.q;
        num_i       = v.i;
        cur_ratio   = v.ratio;
        cur_special = v.special;
        cur_lat     = v.lat;
        in_valid    = 1'b1;
        start       = acc_count;
        ok          = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #2;
            if (acc_count != start) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout: q=%08h i=%08h", v.q, v.i);
        end
        if (!hold) begin
            in_valid = 1'b0;
            num_q    = $urandom;  // must not disturb the operation in flight
            num_i    = $urandom;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL result_timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int p0;
        int p1;
        int p2;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, LatNorm};
        vecs[1]  = '{32'hC0400000, 32'h40000000, 32'hBFC00000, 1'b0, LatNorm};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, LatNorm};
        vecs[3]  = '{32'hC0A00000, 32'h00000000, 32'hFF7FFFFF, 1'b1, LatSpec};
        vecs[4]  = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0, LatSpec};
        vecs[5]  = '{32'h7E800000, 32'h00800000, 32'h7F7FFFFF, 1'b1, LatNorm};
        vecs[6]  = '{32'h00800000, 32'h7E800000, 32'h00000000, 1'b0, LatNorm};
        vecs[7]  = '{32'h7F800000, 32'h3F800000, 32'h7F7FFFFF, 1'b1, LatSpec};
        vecs[8]  = '{32'h40C00000, 32'hBFC00000, 32'hC0800000, 1'b0, LatNorm};
        vecs[9]  = '{32'h7FC00000, 32'h3F800000, 32'h7F7FFFFF, 1'b1, LatSpec};
        vecs[10] = '{32'h3F800000, 32'h7F800000, 32'h7F7FFFFF, 1'b1, LatSpec};

        rst      = 1'b1;
        in_valid = 1'b0;
        num_q    = 32'h0;
        num_i    = 32'h0;
        repeat (3) @(negedge clk);
        check_val("reset_in_ready", {31'h0, in_ready}, 32'h0);
        check_val("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check_val("reset_num_ratio", num_ratio, 32'h0);
        check_val("reset_out_special", {31'h0, out_special}, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("in_ready_after_reset", {31'h0, in_ready}, 32'h1);

        foreach (vecs[n]) begin
            send(vecs[n], 1'b0);
            wait_done();
        end

        // Back-to-back with in_valid held high.
        send(vecs[0], 1'b1);
        p0 = last_acc_cyc;
        send(vecs[1], 1'b1);
        p1 = last_acc_cyc;
        send(vecs[8], 1'b1);
        p2 = last_acc_cyc;
        in_valid = 1'b0;
        check_val("b2b_spacing_1", p1 - p0, 32'd29);
        check_val("b2b_spacing_2", p2 - p1, 32'd29);
        wait_done();

        // Reset during DIVIDE discards the result.
        send(vecs[1], 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check_val("midrst_num_ratio", num_ratio, 32'h0);
        check_val("midrst_out_special", {31'h0, out_special}, 32'h0);
        check_val("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("midrst_in_ready_release", {31'h0, in_ready}, 32'h1);
        repeat (40) @(posedge clk);
        #2;
        check_val("midrst_ratio_after", num_ratio, 32'h0);
        send(vecs[2], 1'b0);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
